// File: rtl/watch_pkg.sv
// Shared types and constants for the watch alarm controller.
// Optional feature macro: ALARM_SNOOZE_EN adds the SNOOZE state.
package watch_pkg;

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, RING, SNOOZE} state_t;
`else
  typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, RING} state_t;
`endif

  // editSel codes (drive the blinking digit pair on the display)
  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_HOURS = 2'b01;
  localparam logic [1:0] SEL_MINS  = 2'b10;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  // Alarm time as four BCD digits, HH:MM
  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcdTime_t;

  function automatic logic [1:0] selFor(state_t s);
    case (s)
      EDIT_H:  return SEL_HOURS;
      EDIT_M:  return SEL_MINS;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Button/tick/match inputs and display/alarm outputs of alarm_ctrl.
//  slave  : controller side (inputs are buttons, tick, match)
//  master : environment side (buttons, tick source, comparator, display)
interface alarm_ctrl_if;
  logic       tick1Hz;
  logic       btnMode;
  logic       btnNext;
  logic       btnInc;
  logic       alarmMatch;
  logic [3:0] editH1;
  logic [3:0] editH0;
  logic [3:0] editM1;
  logic [3:0] editM0;
  logic       alarmSet;
  logic       alarmEnable;
  logic       ringing;
  logic [1:0] editSel;

  modport slave (
    input  tick1Hz, btnMode, btnNext, btnInc, alarmMatch,
    output editH1, editH0, editM1, editM0, alarmSet, alarmEnable, ringing, editSel
  );

  modport master (
    output tick1Hz, btnMode, btnNext, btnInc, alarmMatch,
    input  editH1, editH0, editM1, editM0, alarmSet, alarmEnable, ringing, editSel
  );
endinterface

// File: rtl/alarm_ctrl_bcd2_inc.sv
// bcd2_inc: combinational two-digit BCD increment that wraps to 00 after LIMIT.
//  inHi/inLo   : current tens/units digit
//  outHi/outLo : incremented value
module bcd2_inc #(
  parameter int LIMIT = 59
) (
  input  logic [3:0] inHi,
  input  logic [3:0] inLo,
  output logic [3:0] outHi,
  output logic [3:0] outLo
);
  localparam logic [3:0] LIM_HI = 4'(LIMIT / 10);
  localparam logic [3:0] LIM_LO = 4'(LIMIT % 10);

  always_comb begin
    outHi = inHi;
    outLo = inLo + 4'd1;
    if (inHi == LIM_HI && inLo == LIM_LO) begin
      outHi = 4'd0;
      outLo = 4'd0;
    end else if (inLo == 4'd9) begin
      outHi = inHi + 4'd1;
      outLo = 4'd0;
    end
  end
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: mode/sequencing controller for the watch alarm.
//  clk, reset : clock, async active-high reset
//  bus.slave  : tick1Hz, btnMode/btnNext/btnInc pulses, alarmMatch level in;
//               edit digits, alarmSet pulse, alarmEnable, ringing, editSel out
// Optional feature macro: ALARM_SNOOZE_EN (snooze on btnInc while ringing).
// All outputs are registered and reflect the state entered on the last edge.
module alarm_ctrl
  import watch_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        reset,
  alarm_ctrl_if.slave bus
);

  state_t     state, nextState;
  bcdTime_t   editT, savedT;
  logic [CNT_W-1:0] secCnt;
  logic       matchQ, enQ, setQ, ringQ;
  logic [1:0] selQ;
  logic       rise;
  logic       incH, incM, commit, abort, toggleEn, cntInc;
  logic [3:0] hNxt1, hNxt0, mNxt1, mNxt0;

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);
  logic [SNZ_W-1:0] snoozeCnt;
  logic             snzInc;
`else
  logic unusedCfg;
  assign unusedCfg = ^{SNOOZE_SECS[0], MAX_SNOOZE[0]};
`endif

  // Only a fresh match edge can start ringing; a level left high after
  // dismissal or across an edit session never re-triggers.
  assign rise = bus.alarmMatch & ~matchQ;

  bcd2_inc #(.LIMIT(HOUR_MAX)) uHourInc (
    .inHi(editT.h1), .inLo(editT.h0), .outHi(hNxt1), .outLo(hNxt0)
  );
  bcd2_inc #(.LIMIT(MIN_MAX)) uMinInc (
    .inHi(editT.m1), .inLo(editT.m0), .outHi(mNxt1), .outLo(mNxt0)
  );

  always_comb begin
    nextState = state;
    incH      = 1'b0;
    incM      = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    toggleEn  = 1'b0;
    cntInc    = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snzInc    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.btnMode)           toggleEn  = 1'b1;
        else if (bus.btnNext)      nextState = EDIT_H;
        else if (rise && enQ)      nextState = RING;
      end
      EDIT_H: begin
        if (bus.btnMode) begin
          abort     = 1'b1;
          nextState = IDLE;
        end else if (bus.btnNext)  nextState = EDIT_M;
        else if (bus.btnInc)       incH      = 1'b1;
      end
      EDIT_M: begin
        if (bus.btnMode) begin
          abort     = 1'b1;
          nextState = IDLE;
        end else if (bus.btnNext) begin
          commit    = 1'b1;
          nextState = IDLE;
        end else if (bus.btnInc)   incM      = 1'b1;
      end
      RING: begin
        // Buttons take precedence over a coincident tick.
        if (bus.btnMode || bus.btnNext) nextState = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (bus.btnInc) begin
          if (32'(snoozeCnt) < MAX_SNOOZE) begin
            nextState = SNOOZE;
            snzInc    = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end
`else
        else if (bus.btnInc)       nextState = IDLE;
`endif
        else if (bus.tick1Hz) begin
          if (secCnt == CNT_W'(RING_SECS - 1)) nextState = IDLE;
          else                                 cntInc    = 1'b1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (bus.btnMode || bus.btnNext) nextState = IDLE;
        else if (bus.tick1Hz) begin
          if (secCnt == CNT_W'(SNOOZE_SECS - 1)) nextState = RING;
          else                                   cntInc    = 1'b1;
        end
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      matchQ    <= 1'b0;
      editT     <= '0;
      savedT    <= '0;
      secCnt    <= '0;
      enQ       <= 1'b0;
      setQ      <= 1'b0;
      ringQ     <= 1'b0;
      selQ      <= SEL_NONE;
`ifdef ALARM_SNOOZE_EN
      snoozeCnt <= '0;
`endif
    end else begin
      state  <= nextState;
      matchQ <= bus.alarmMatch;
      setQ   <= commit;
      ringQ  <= (nextState == RING);
      selQ   <= selFor(nextState);

      if (toggleEn)    enQ <= ~enQ;
      else if (commit) enQ <= 1'b1;

      // Every state change restarts the second counter.
      if (nextState != state) secCnt <= '0;
      else if (cntInc)        secCnt <= secCnt + 1'b1;

      if (abort)      editT <= savedT;
      else if (incH) begin
        editT.h1 <= hNxt1;
        editT.h0 <= hNxt0;
      end else if (incM) begin
        editT.m1 <= mNxt1;
        editT.m0 <= mNxt0;
      end

      if (commit) savedT <= editT;

`ifdef ALARM_SNOOZE_EN
      if (state == IDLE && nextState == RING) snoozeCnt <= '0;
      else if (snzInc)                        snoozeCnt <= snoozeCnt + 1'b1;
`endif
    end
  end

  assign bus.editH1      = editT.h1;
  assign bus.editH0      = editT.h0;
  assign bus.editM1      = editT.m1;
  assign bus.editM0      = editT.m0;
  assign bus.alarmSet    = setQ;
  assign bus.alarmEnable = enQ;
  assign bus.ringing     = ringQ;
  assign bus.editSel     = selQ;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: table vectors, directed corner cases
// and randomized traffic against an integer-level behavioural model.
module tb_alarm_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_ctrl_if bus();
  alarm_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef ALARM_SNOOZE_EN
  localparam bit HAS_SNZ = 1'b1;
`else
  localparam bit HAS_SNZ = 1'b0;
`endif

  int nCmp = 0;
  int nBad = 0;

  // Behavioural model: modes as small ints, time as plain hours/minutes.
  localparam int M_IDLE = 0, M_EH = 1, M_EM = 2, M_RING = 3, M_SNZ = 4;
  int mMode, mH, mM, mSH, mSM, mSecs, mSnz;
  bit mEn, mSet, mPrev;
  bit matchLvl;

  typedef struct {
    bit bm, bn, bi;
    logic [20:0] exp;
  } vec_t;

  function automatic logic [20:0] pk(int h, int m, int sel, bit set, bit en, bit ring);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 2'(sel), set, en, ring};
  endfunction

  function automatic logic [20:0] actual();
    return {bus.editH1, bus.editH0, bus.editM1, bus.editM0, bus.editSel,
            bus.alarmSet, bus.alarmEnable, bus.ringing};
  endfunction

  function automatic logic [20:0] modelOut();
    int sel;
    sel = (mMode == M_EH) ? 1 : (mMode == M_EM) ? 2 : 0;
    return pk(mH, mM, sel, mSet, mEn, mMode == M_RING);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE; mH = 0; mM = 0; mSH = 0; mSM = 0; mSecs = 0; mSnz = 0;
    mEn = 0; mSet = 0; mPrev = 0;
  endtask

  task automatic modelStep(input bit bm, input bit bn, input bit bi, input bit tk, input bit mt);
    bit rise;
    rise  = mt && !mPrev;
    mPrev = mt;
    mSet  = 0;
    case (mMode)
      M_IDLE:
        if (bm) mEn = !mEn;
        else if (bn) mMode = M_EH;
        else if (rise && mEn) begin mMode = M_RING; mSecs = 0; mSnz = 0; end
      M_EH:
        if (bm) begin mMode = M_IDLE; mH = mSH; mM = mSM; end
        else if (bn) mMode = M_EM;
        else if (bi) mH = (mH + 1) % 24;
      M_EM:
        if (bm) begin mMode = M_IDLE; mH = mSH; mM = mSM; end
        else if (bn) begin mSH = mH; mSM = mM; mSet = 1; mEn = 1; mMode = M_IDLE; end
        else if (bi) mM = (mM + 1) % 60;
      M_RING:
        if (bm || bn) mMode = M_IDLE;
        else if (bi) begin
          if (HAS_SNZ && mSnz < 3) begin mSnz++; mMode = M_SNZ; mSecs = 0; end
          else mMode = M_IDLE;
        end else if (tk) begin
          mSecs++;
          if (mSecs == 60) mMode = M_IDLE;
        end
      default:
        if (bm || bn) mMode = M_IDLE;
        else if (tk) begin
          mSecs++;
          if (mSecs == 300) begin mMode = M_RING; mSecs = 0; end
        end
    endcase
  endtask

  // One clock: drive at negedge, clock, advance model, settle.
  task automatic cyc(input bit bm, input bit bn, input bit bi, input bit tk);
    @(negedge clk);
    bus.btnMode = bm; bus.btnNext = bn; bus.btnInc = bi;
    bus.tick1Hz = tk; bus.alarmMatch = matchLvl;
    @(posedge clk);
    modelStep(bm, bn, bi, tk, matchLvl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    matchLvl = 0;
    bus.btnMode = 0; bus.btnNext = 0; bus.btnInc = 0;
    bus.tick1Hz = 0; bus.alarmMatch = 0;
    modelReset();
    #1;
    check("resetState", 32'(actual()), 32'(pk(0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    bit sawSet;
    reset = 1'b1;
    bus.btnMode = 0; bus.btnNext = 0; bus.btnInc = 0;
    bus.tick1Hz = 0; bus.alarmMatch = 0;
    matchLvl = 0;

    // Basic edit/commit: 03:02 via Next, 3xInc, Next, 2xInc, Next.
    vecs[0] = '{0, 1, 0, pk(0, 0, 1, 0, 0, 0)};
    vecs[1] = '{0, 0, 1, pk(1, 0, 1, 0, 0, 0)};
    vecs[2] = '{0, 0, 1, pk(2, 0, 1, 0, 0, 0)};
    vecs[3] = '{0, 0, 1, pk(3, 0, 1, 0, 0, 0)};
    vecs[4] = '{0, 1, 0, pk(3, 0, 2, 0, 0, 0)};
    vecs[5] = '{0, 0, 1, pk(3, 1, 2, 0, 0, 0)};
    vecs[6] = '{0, 0, 1, pk(3, 2, 2, 0, 0, 0)};
    vecs[7] = '{0, 1, 0, pk(3, 2, 0, 1, 1, 0)};
    vecs[8] = '{0, 0, 0, pk(3, 2, 0, 0, 1, 0)};

    doReset();
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].bm, vecs[i].bn, vecs[i].bi, 0);
      check($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
    end

    // Hour wrap 23 -> 00, minute wrap 59 -> 00 without hour carry, abort.
    doReset();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 23; i++) cyc(0, 0, 1, 0);
    check("hour23", 32'({bus.editH1, bus.editH0}), 32'h23);
    cyc(0, 0, 1, 0);
    check("hourWrap", 32'({bus.editH1, bus.editH0}), 32'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 1, 0);
    check("min59", 32'({bus.editH1, bus.editH0, bus.editM1, bus.editM0}), 32'h0559);
    cyc(0, 0, 1, 0);
    check("minWrap", 32'({bus.editH1, bus.editH0, bus.editM1, bus.editM0}), 32'h0500);
    cyc(1, 0, 0, 0);
    check("abortToZero", 32'(actual()), 32'(pk(0, 0, 0, 0, 0, 0)));

    // Commit 07:30, re-edit to 08, abort restores 07:30 with no alarmSet.
    doReset();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    check("commit0730", 32'(actual()), 32'(pk(7, 30, 0, 1, 1, 0)));
    sawSet = 0;
    cyc(0, 1, 0, 0); sawSet |= bus.alarmSet;
    cyc(0, 0, 1, 0); sawSet |= bus.alarmSet;
    check("reedit08", 32'({bus.editH1, bus.editH0, bus.editM1, bus.editM0}), 32'h0830);
    cyc(1, 0, 0, 0); sawSet |= bus.alarmSet;
    idle(1);         sawSet |= bus.alarmSet;
    check("abortNoSet", 32'(sawSet), 32'(0));
    check("abortRestore", 32'(actual()), 32'(pk(7, 30, 0, 0, 1, 0)));

    // Match rise rings; 60 ticks auto-dismiss.
    idle(1);
    check("preRing", 32'(bus.ringing), 32'(0));
    matchLvl = 1;
    cyc(0, 0, 0, 0);
    check("ringStart", 32'(bus.ringing), 32'(1));
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1);
    check("ring59", 32'(bus.ringing), 32'(1));
    cyc(0, 0, 0, 1);
    check("ringTimeout", 32'(actual()), 32'(pk(7, 30, 0, 0, 1, 0)));
    idle(3);
    check("noRetrigLevel", 32'(bus.ringing), 32'(0));

    // Dismiss with btnNext and tick in the same cycle.
    matchLvl = 0; idle(1);
    matchLvl = 1; idle(1);
    check("ring2", 32'(bus.ringing), 32'(1));
    cyc(0, 1, 0, 1);
    check("dismissBeatsTick", 32'(actual()), 32'(pk(7, 30, 0, 0, 1, 0)));

    // A rise during EDIT_M is dropped.
    matchLvl = 0;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    matchLvl = 1;
    cyc(0, 0, 0, 0);
    check("riseInEdit", 32'({bus.editSel, bus.ringing}), 32'({2'b10, 1'b0}));
    cyc(1, 0, 0, 0);
    idle(3);
    check("riseDropped", 32'(bus.ringing), 32'(0));

    // Snooze behaviour (or immediate dismiss without the feature).
    matchLvl = 0; idle(1);
    matchLvl = 1; idle(1);
    check("ring3", 32'(bus.ringing), 32'(1));
    if (HAS_SNZ) begin
      for (int s = 0; s < 3; s++) begin
        cyc(0, 0, 1, 0);
        check($sformatf("snooze%0d", s), 32'(bus.ringing), 32'(0));
        for (int i = 0; i < 299; i++) cyc(0, 0, 0, 1);
        check($sformatf("snooze%0d_299", s), 32'(bus.ringing), 32'(0));
        cyc(0, 0, 0, 1);
        check($sformatf("reRing%0d", s), 32'(bus.ringing), 32'(1));
      end
      cyc(0, 0, 1, 0);
      check("snoozeLimit", 32'(bus.ringing), 32'(0));
      for (int i = 0; i < 300; i++) cyc(0, 0, 0, 1);
      check("snoozeLimitStays", 32'(actual()), 32'(pk(7, 30, 0, 0, 1, 0)));
    end else begin
      cyc(0, 0, 1, 0);
      check("incDismiss", 32'(actual()), 32'(pk(7, 30, 0, 0, 1, 0)));
    end

    // Reset while ringing clears everything at once.
    matchLvl = 0; idle(1);
    matchLvl = 1; idle(1);
    check("ring4", 32'(bus.ringing), 32'(1));
    doReset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit bm, bn, bi, tk;
      bm = ($urandom_range(0, 99) < 5);
      bn = ($urandom_range(0, 99) < 10);
      bi = ($urandom_range(0, 99) < 25);
      tk = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 99) < 4) matchLvl = !matchLvl;
      cyc(bm, bn, bi, tk);
      check($sformatf("rand%0d", n), 32'(actual()), 32'(modelOut()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
